// File: rtl/usb_rx_pkg.sv
// Shared types for the low-speed USB receive path: line states and receiver FSM encoding.
package types;

    // Encoded as {d_p, d_n} so the synchronized pin pair maps straight onto the type.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE  = 3'd0;
    localparam rx_state_t RX_SYNC  = 3'd1;
    localparam rx_state_t RX_DATA  = 3'd2;
    localparam rx_state_t RX_EOP   = 3'd3;
    localparam rx_state_t RX_ABORT = 3'd4;

endpackage

// File: rtl/usb_rx_line_sync.sv
// Pin synchronizer, line-state decode and bit-timing DPLL for the low-speed receiver.
module usb_line_sync
    import types::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        d_p_i,
    input  logic        d_n_i,
    output line_state_t line_state_o,
    output logic        bit_strobe_o
);

    localparam int PW = $clog2(CLKS_PER_BIT);

    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Phase is 0 in the first cycle the new synchronized state is visible.
    always_comb begin
        phase_d = phase_q + PW'(1);
        if (meta_q != sync_q) begin
            phase_d = '0;
        end else if (phase_q == PW'(CLKS_PER_BIT - 1)) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 2'b01;
            sync_q  <= 2'b01;
            phase_q <= '0;
        end else begin
            meta_q  <= {d_p_i, d_n_i};
            sync_q  <= meta_q;
            phase_q <= phase_d;
        end
    end

    assign line_state_o = line_state_t'(sync_q);
    assign bit_strobe_o = (phase_q == PW'(CLKS_PER_BIT / 2));

endmodule

// File: rtl/usb_rx.sv
// Low-speed USB receive front end: NRZI decode, SYNC/EOP detection, unstuffing, byte assembly.
module usb_rx
    import types::*;
#(
    parameter int CLKS_PER_BIT     = 16,
    parameter int BUS_RESET_CYCLES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_p,
    input  logic       d_n,
    output logic [7:0] rx_data,
    output logic       rx_active,
    output logic       rx_valid,
    output logic       rx_error,
    output logic       bus_reset,
    output rx_state_t  dbg_state
);

    localparam int CW = $clog2(BUS_RESET_CYCLES + 1);

    line_state_t line_state;
    logic        bit_strobe;
    logic        nrzi_bit;

    rx_state_t   state_q, state_d;
    line_state_t prev_q, prev_d;
    logic [2:0]  zeros_q, zeros_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        error_q, error_d;
    logic        jseen_q, jseen_d;
    logic [CW-1:0] se0_cnt_q, se0_cnt_d;
    logic        bus_reset_q, bus_reset_d;

    usb_line_sync #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_line_sync (
        .clk_i        (clk),
        .rst_ni       (reset),
        .d_p_i        (d_p),
        .d_n_i        (d_n),
        .line_state_o (line_state),
        .bit_strobe_o (bit_strobe)
    );

    assign nrzi_bit = (line_state == prev_q);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        zeros_d  = zeros_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        active_d = active_q;
        error_d  = error_q;
        jseen_d  = jseen_q;
        if (bus_reset_q) begin
            state_d  = RX_IDLE;
            prev_d   = LS_J;
            active_d = 1'b0;
            error_d  = 1'b0;
            jseen_d  = 1'b0;
        end else if (bit_strobe) begin
            prev_d = line_state;
            case (state_q)
                RX_IDLE: begin
                    // The K that leaves idle is itself the first SYNC zero.
                    if (line_state == LS_K) begin
                        state_d = RX_SYNC;
                        zeros_d = 3'd1;
                    end else begin
                        prev_d = LS_J;
                    end
                end
                RX_SYNC: begin
                    if (line_state == LS_SE0 || line_state == LS_SE1) begin
                        state_d = RX_IDLE;
                        prev_d  = LS_J;
                    end else if (!nrzi_bit) begin
                        if (zeros_q != 3'd7) zeros_d = zeros_q + 3'd1;
                    end else if (zeros_q >= 3'd4) begin
                        state_d  = RX_DATA;
                        active_d = 1'b1;
                        ones_d   = 3'd0;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                        prev_d  = LS_J;
                    end
                end
                RX_DATA: begin
                    if (line_state == LS_SE0 && bitcnt_q == 3'd0) begin
                        state_d = RX_EOP;
                    end else if (line_state == LS_SE0 || line_state == LS_SE1 ||
                                 (ones_q == 3'd6 && nrzi_bit)) begin
                        state_d = RX_ABORT;
                        error_d = 1'b1;
                        jseen_d = 1'b0;
                    end else if (ones_q == 3'd6) begin
                        ones_d = 3'd0;
                    end else begin
                        shift_d  = {nrzi_bit, shift_q[7:1]};
                        ones_d   = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            data_d  = {nrzi_bit, shift_q[7:1]};
                            valid_d = 1'b1;
                        end
                    end
                end
                RX_EOP: begin
                    if (line_state == LS_J) begin
                        state_d  = RX_IDLE;
                        prev_d   = LS_J;
                        active_d = 1'b0;
                    end else if (line_state != LS_SE0) begin
                        state_d = RX_ABORT;
                        error_d = 1'b1;
                        jseen_d = 1'b0;
                    end
                end
                RX_ABORT: begin
                    if (line_state == LS_J && jseen_q) begin
                        state_d  = RX_IDLE;
                        prev_d   = LS_J;
                        active_d = 1'b0;
                        error_d  = 1'b0;
                        jseen_d  = 1'b0;
                    end else begin
                        jseen_d = (line_state == LS_J);
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                    prev_d  = LS_J;
                end
            endcase
        end
    end

    // SE0 run length is tracked on every cycle, independent of the bit strobe.
    always_comb begin
        se0_cnt_d   = '0;
        bus_reset_d = 1'b0;
        if (line_state == LS_SE0) begin
            se0_cnt_d   = (se0_cnt_q == CW'(BUS_RESET_CYCLES)) ? se0_cnt_q : se0_cnt_q + CW'(1);
            bus_reset_d = (se0_cnt_q >= CW'(BUS_RESET_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            prev_q      <= LS_J;
            zeros_q     <= 3'd0;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
            jseen_q     <= 1'b0;
            se0_cnt_q   <= '0;
            bus_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            zeros_q     <= zeros_d;
            ones_q      <= ones_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            error_q     <= error_d;
            jseen_q     <= jseen_d;
            se0_cnt_q   <= se0_cnt_d;
            bus_reset_q <= bus_reset_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_active = active_q;
    assign rx_error  = error_q;
    assign bus_reset = bus_reset_q;
    assign dbg_state = state_q;

endmodule
